// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op-select width, op codes,
// FSM state encodings and small op-classification helpers.
package seq_alu_pkg;

  localparam int ALU_OPTION_WIDTH = 4;

  localparam logic [ALU_OPTION_WIDTH-1:0] OP_ADD   = 4'd0;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SUB   = 4'd1;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_AND   = 4'd2;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_OR    = 4'd3;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SLT   = 4'd4;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SLTU  = 4'd5;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_MUL   = 4'd6;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_MULHU = 4'd7;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_DIVU  = 4'd8;
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_REMU  = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mul_op(input logic [ALU_OPTION_WIDTH-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [ALU_OPTION_WIDTH-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for the sequential ALU: shift-add multiplier (LSB first)
// and, when SEQ_ALU_DIV_EN is defined, a restoring unsigned divider (MSB first).
// The exposed product/quotient/remainder are the values *after* the iteration
// applied on the current step, so the controller can capture the final answer
// on the same edge that performs the last iteration.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_ALU_DIV_EN
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
`endif
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper_sum;

  // Next product: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole register right by one.
  always_comb begin
    addend    = prod_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    product   = {upper_sum, prod_q[WIDTH-1:1]};
  end

  // Multiplier registers: multiplier sits in the low half on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
    end else if (load) begin
      prod_q  <= {{WIDTH{1'b0}}, a};
      mcand_q <= b;
    end else if (step && !mode) begin
      prod_q  <= product;
    end
  end

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // Restoring step: shift the next dividend bit into the WIDTH+1-bit partial
  // remainder and subtract the divisor only if it fits. The kept remainder is
  // always below the divisor, so WIDTH bits are enough to store it.
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    fits      = (shifted >= {1'b0, dvsr_q});
    remainder = fits ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
    quotient  = {quo_q[WIDTH-2:0], fits};
  end

  // Divider registers: dividend bits are consumed from the quotient register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= a;
      dvsr_q <= b;
    end else if (step && mode) begin
      rem_q  <= remainder;
      quo_q  <= quotient;
    end
  end
`endif

endmodule

// File: rtl/seq_alu.sv
// Sequential EX-stage ALU: single-cycle base ops plus iterative MUL/MULHU and,
// with SEQ_ALU_DIV_EN defined, DIVU/REMU, over a start/ready/done handshake.
// Without SEQ_ALU_DIV_EN, codes 8/9 behave as illegal (single-cycle, result 0).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        flush,
  input  logic [ALU_OPTION_WIDTH-1:0] ALU_option,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  output logic                        ready,
  output logic                        done,
  output logic [WIDTH-1:0]            result
);

  logic [1:0]                  state;
  logic [CNT_W-1:0]            cnt;
  logic [ALU_OPTION_WIDTH-1:0] op_q;
  logic [WIDTH-1:0]            single_result;
  logic [WIDTH-1:0]            iter_result;
  logic [2*WIDTH-1:0]          product;
  logic                        goes_iter;
  logic                        load;
  logic                        step;
  logic                        mode;

  assign ready = (state != ST_BUSY);
  assign done  = (state == ST_DONE);
  assign load  = start && ready && !flush && goes_iter;
  assign step  = (state == ST_BUSY);

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  assign mode      = is_div_op(op_q);
  assign goes_iter = is_mul_op(ALU_option) || (is_div_op(ALU_option) && (B != '0));
`else
  assign mode      = 1'b0;
  assign goes_iter = is_mul_op(ALU_option);
`endif

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .mode     (mode),
    .a        (A),
    .b        (B),
`ifdef SEQ_ALU_DIV_EN
    .quotient (quotient),
    .remainder(remainder),
`endif
    .product  (product)
  );

  // Single-cycle results, including divide-by-zero and illegal codes.
  always_comb begin
    single_result = '0;
    case (ALU_option)
      OP_ADD:  single_result = A + B;
      OP_SUB:  single_result = A - B;
      OP_AND:  single_result = A & B;
      OP_OR:   single_result = A | B;
      OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, (A < B)};
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: single_result = '1;
      OP_REMU: single_result = A;
`endif
      default: single_result = '0;
    endcase
  end

  // Final iterative result, selected by the op latched at accept.
  always_comb begin
    iter_result = '0;
    case (op_q)
      OP_MUL:   iter_result = product[WIDTH-1:0];
      OP_MULHU: iter_result = product[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU:  iter_result = quotient;
      OP_REMU:  iter_result = remainder;
`endif
      default:  iter_result = '0;
    endcase
  end

  // Control FSM: flush kills everything in flight and drops a same-cycle start;
  // DONE accepts a new start directly so back-to-back ops have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (goes_iter) begin
              state <= ST_BUSY;
              cnt   <= CNT_W'(WIDTH);
              op_q  <= ALU_option;
            end else begin
              state  <= ST_DONE;
              result <= single_result;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= ST_DONE;
            result <= iter_result;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32). Expectations adapt to whether
// SEQ_ALU_DIV_EN is defined for the build.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_LAT = DIV_EN ? W + 1 : 1;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [3:0]   ALU_option;
  logic [W-1:0] A, B;
  logic         ready, done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .ALU_option(ALU_option),
    .A         (A),
    .B         (B),
    .ready     (ready),
    .done      (done),
    .result    (result)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Next edge, then sample/drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request now (caller is away from the edge); returns in cycle t+1.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALU_option = op;
    A          = a;
    B          = b;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    A          = $urandom;
    B          = $urandom;
    ALU_option = 4'($urandom_range(0, 15));
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    drive(op, a, b);
  endtask

  // Wait (bounded) for done, then compare latency, busy span and result.
  task automatic checkOutput(input string name);
    int cyc  = 1;
    int busy = 0;
    logic [W-1:0] exp;
    int lat;
    while (!done && cyc < 100) begin
      if (!ready) busy++;
      tick();
      cyc++;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: done seen with empty scoreboard", name);
      return;
    end
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({name, " done"}, W'(done), W'(1));
    check({name, " latency"}, W'(cyc), W'(lat));
    check({name, " busy"}, W'(busy), W'(lat - 1));
    check({name, " result"}, result, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      OP_MUL:   return p[W-1:0];
      OP_MULHU: return p[2*W-1:W];
      OP_DIVU:  return DIV_EN ? a / b : '0;
      OP_REMU:  return DIV_EN ? a % b : '0;
      default:  return '0;
    endcase
  endfunction

  initial begin
    logic [W-1:0] prior;
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    int           done_seen;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    ALU_option = '0; A = '0; B = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset ready", W'(ready), W'(1));
    check("reset done", W'(done), W'(0));
    check("reset result", result, '0);

    vecs.push_back('{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1});
    vecs.push_back('{OP_SLT,   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1});
    vecs.push_back('{OP_SUB,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1});
    vecs.push_back('{OP_AND,   32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1});
    vecs.push_back('{OP_OR,    32'h1200_0034, 32'h0000_5600, 32'h1200_5634, 1});
    vecs.push_back('{OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1});
    vecs.push_back('{OP_SLT,   32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1});
    vecs.push_back('{OP_SLTU,  32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1});
    vecs.push_back('{OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, W + 1});
    vecs.push_back('{OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, W + 1});
    vecs.push_back('{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, W + 1});
    vecs.push_back('{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W + 1});
    vecs.push_back('{OP_MUL,   32'd12345,     32'd678,       32'd8369910,   W + 1});
    vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         DIV_EN ? 32'd14 : 32'd0, DIV_LAT});
    vecs.push_back('{OP_REMU,  32'd100,       32'd7,         DIV_EN ? 32'd2 : 32'd0,  DIV_LAT});
    vecs.push_back('{OP_DIVU,  32'd100,       32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1});
    vecs.push_back('{OP_REMU,  32'd5,         32'd0,         DIV_EN ? 32'd5 : 32'd0,  1});
    vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_LAT});
    vecs.push_back('{OP_REMU,  32'hFFFF_FFFF, 32'd10,        DIV_EN ? 32'd5 : 32'd0,  DIV_LAT});
    vecs.push_back('{4'd10,    32'd3,         32'd4,         32'd0, 1});
    vecs.push_back('{4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1});

    // Each op is started during the previous DONE cycle, exercising the no-bubble path.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      checkOutput($sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    // done is a single-cycle pulse when no new start follows.
    tick();
    check("done pulse width", W'(done), W'(0));

    // Randomised iterative ops against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom | 32'h1;
      rop = 4'(6 + (i % 4));
      applyStimulus(rop, ra, rb, model(rop, ra, rb), (rop >= OP_DIVU) ? DIV_LAT : W + 1);
      checkOutput($sformatf("rand%0d op%0d", i, rop));
    end
    tick();

    // Flush a MUL at cycle t+10: no done, result untouched, then ADD 2+3.
    prior = result;
    drive(OP_MUL, 32'd9, 32'd9);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush ready", W'(ready), W'(1));
    check("flush done", W'(done), W'(0));
    check("flush result", result, prior);
    done_seen = 0;
    repeat (W + 5) begin
      if (done) done_seen++;
      tick();
    end
    check("flush no late done", W'(done_seen), W'(0));
    check("flush result held", result, prior);

    // start together with flush is dropped.
    ALU_option = OP_ADD; A = 32'd40; B = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start done", W'(done), W'(0));
    check("flush+start result", result, prior);

    applyStimulus(OP_ADD, 32'd2, 32'd3, 32'd5, 1);
    checkOutput("post-flush add");

    // start held high through BUSY must be ignored and not queued.
    applyStimulus(OP_MUL, 32'd3, 32'd5, 32'd15, W + 1);
    fork
      begin
        repeat (W) begin
          ALU_option = OP_ADD; A = 32'd1; B = 32'd1; start = 1'b1;
          tick();
        end
        start = 1'b0;
      end
      checkOutput("mul under start spam");
    join
    tick();
    check("spam no extra done", W'(done), W'(0));
    check("spam result held", result, 32'd15);

    // Reset in the middle of an iterative op.
    drive(DIV_EN ? OP_DIVU : OP_MUL, 32'd100, 32'd7);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-op reset ready", W'(ready), W'(1));
    check("mid-op reset done", W'(done), W'(0));
    check("mid-op reset result", result, '0);
    done_seen = 0;
    repeat (W + 5) begin
      if (done) done_seen++;
      tick();
    end
    check("mid-op reset no done", W'(done_seen), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
